// File: rtl/ram_arbiter_pkg.sv
// Shared state encoding, master indices and RAM bus widths for the data-RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int RAM_ADDR_W    = 32;
  localparam int RAM_DATA_W    = 32;
  localparam int RAM_BE_W      = RAM_DATA_W / 8;
  localparam int DEF_MAX_BURST = 16;
  localparam int BURST_CNT_W   = 8;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational one-hot pick between m0/m1: lock pins the RAM to m1, conflicts go
// round-robin when RAM_ARB_RR_EN is defined, otherwise m0 always wins. No state, no latency.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  input  logic       i_lock,
  output logic [1:0] o_pick
);

`ifndef RAM_ARB_RR_EN
  logic w_unused_last_gnt;
  assign w_unused_last_gnt = i_last_gnt;
`endif

  always_comb begin
    o_pick = 2'b00;
    if (i_lock) begin
      o_pick[M1] = i_req[M1];
    end else if (i_req[M0] && i_req[M1]) begin
`ifdef RAM_ARB_RR_EN
      if (i_last_gnt == M0) o_pick[M1] = 1'b1;
      else                  o_pick[M0] = 1'b1;
`else
      o_pick[M0] = 1'b1;
`endif
    end else begin
      o_pick = i_req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master sequencer for the single-port data RAM (RR conflicts under RAM_ARB_RR_EN).
// Grant in cycle N, RAM access N+1, done/rdata N+2; masters hold requests until gnt.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [RAM_BE_W-1:0] m0_vldbyte_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_done_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [RAM_BE_W-1:0] m1_vldbyte_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic                m1_lock_i,
  output logic                m1_gnt_o,
  output logic                m1_done_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [RAM_BE_W-1:0] ram_vldbyte_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i
);

  localparam logic [BURST_CNT_W-1:0] LP_MAX_BURST = BURST_CNT_W'(MAX_BURST);

  state_t                 r_state;
  logic                   r_owner;
  logic                   r_last_gnt;
  logic                   r_lock;
  logic [BURST_CNT_W-1:0] r_burst_cnt;
  logic                   r_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [RAM_BE_W-1:0]    r_vldbyte;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_m0_done;
  logic                   r_m1_done;
  logic [DATA_W-1:0]      r_m0_rdata;
  logic [DATA_W-1:0]      r_m1_rdata;

  logic [1:0]             w_pick;
  logic [1:0]             w_gnt;
  logic                   w_sel;
  logic [BURST_CNT_W-1:0] w_burst_nxt;

  ram_arb_pick u_pick (
    .i_req      ({m1_req_i, m0_req_i}),
    .i_last_gnt (r_last_gnt),
    .i_lock     (r_lock),
    .o_pick     (w_pick)
  );

  assign w_gnt       = (r_state == ST_IDLE) ? w_pick : 2'b00;
  assign w_sel       = w_gnt[M1];
  assign w_burst_nxt = r_burst_cnt + BURST_CNT_W'(1);

  assign m0_gnt_o      = w_gnt[M0];
  assign m1_gnt_o      = w_gnt[M1];
  assign m0_done_o     = r_m0_done;
  assign m1_done_o     = r_m1_done;
  assign m0_rdata_o    = r_m0_rdata;
  assign m1_rdata_o    = r_m1_rdata;
  // ce/we decode straight from state so an async reset drops them mid-access.
  assign ram_ce_o      = (r_state == ST_ACCESS);
  assign ram_we_o      = (r_state == ST_ACCESS) && r_we;
  assign ram_addr_o    = r_addr;
  assign ram_vldbyte_o = r_vldbyte;
  assign ram_wdata_o   = r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= M0;
      r_last_gnt  <= M1;
      r_lock      <= 1'b0;
      r_burst_cnt <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_vldbyte   <= '0;
      r_wdata     <= '0;
      r_m0_done   <= 1'b0;
      r_m1_done   <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_state    <= ST_ACCESS;
            r_owner    <= w_sel;
            r_last_gnt <= w_sel;
            r_we       <= w_sel ? m1_we_i      : m0_we_i;
            r_addr     <= w_sel ? m1_addr_i    : m0_addr_i;
            r_vldbyte  <= w_sel ? m1_vldbyte_i : m0_vldbyte_i;
            r_wdata    <= w_sel ? m1_wdata_i   : m0_wdata_i;
            if (w_sel == M1) begin
              // A burst ends when m1 drops lock or hits the length cap.
              if (!m1_lock_i || (w_burst_nxt == LP_MAX_BURST)) begin
                r_lock      <= 1'b0;
                r_burst_cnt <= '0;
              end else begin
                r_lock      <= 1'b1;
                r_burst_cnt <= w_burst_nxt;
              end
            end
          end
        end
        ST_ACCESS: begin
          r_state <= ST_IDLE;
          if (r_owner == M0) begin
            r_m0_done <= 1'b1;
            if (!r_we) r_m0_rdata <= ram_rdata_i;
          end else begin
            r_m1_done <= 1'b1;
            if (!r_we) r_m1_rdata <= ram_rdata_i;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference of the arbitration and RAM contents.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int MB = 4;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit          vld;
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req_i, m0_we_i, m0_gnt_o, m0_done_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_vldbyte_i;
  logic        m1_req_i, m1_we_i, m1_lock_i, m1_gnt_o, m1_done_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_vldbyte_i;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [3:0]  ram_vldbyte_o;

  logic        clr_mem = 1'b0;
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_vldbyte_i(m0_vldbyte_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_done_o(m0_done_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_vldbyte_i(m1_vldbyte_i), .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
    .m1_gnt_o(m1_gnt_o), .m1_done_o(m1_done_o), .m1_rdata_o(m1_rdata_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_vldbyte_o(ram_vldbyte_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Single-port RAM: byte-lane write on the edge, combinational read.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (ram_ce_o && ram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_vldbyte_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end
  assign ram_rdata_i = mem[ram_addr_o[7:2]];

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_vldbyte_i = '0; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_vldbyte_i = '0; m1_wdata_i = '0;
    m1_lock_i = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_req(input bit m, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    if (!m) begin
      m0_req_i = 1'b1; m0_we_i = we; m0_addr_i = addr; m0_vldbyte_i = be; m0_wdata_i = wd;
    end else begin
      m1_req_i = 1'b1; m1_we_i = we; m1_addr_i = addr; m1_vldbyte_i = be; m1_wdata_i = wd;
    end
  endtask

  // Full request/complete handshake; returns the owner's rdata at done.
  task automatic do_access(input bit m, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd,
                           output logic [31:0] rd);
    int n = 0;
    drive_req(m, we, addr, be, wd);
    @(negedge clk);
    while (!(m ? m1_gnt_o : m0_gnt_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin bad++; $display("FAIL access_gnt got=none want=gnt m%0d", m); end
    @(posedge clk); #1;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rd = m ? m1_rdata_o : m0_rdata_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [137:0] outs;
    idle_inputs();
    rst_n = 1'b0;
    clr_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr_mem = 1'b0;
    outs = {m0_gnt_o, m0_done_o, m0_rdata_o, m1_gnt_o, m1_done_o, m1_rdata_o,
            ram_ce_o, ram_we_o, ram_addr_o, ram_vldbyte_o, ram_wdata_o};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    outs = {m0_gnt_o, m0_done_o, m0_rdata_o, m1_gnt_o, m1_done_o, m1_rdata_o,
            ram_ce_o, ram_we_o, ram_addr_o, ram_vldbyte_o, ram_wdata_o};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL idle_outputs got=%h want=0", outs); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_latency();
    logic [31:0] rd;
    do_access(1'b1, 1'b1, 32'h10, 4'hF, 32'hA1B2C3D4, rd);
    drive_req(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
    @(negedge clk);
    total++;
    if ({m0_gnt_o, m1_gnt_o, ram_ce_o} !== 3'b100) begin
      bad++; $display("FAIL rd_cycle_n got=%b want=100", {m0_gnt_o, m1_gnt_o, ram_ce_o});
    end
    @(posedge clk); #1 m0_req_i = 1'b0;
    @(negedge clk);
    total++;
    if ({ram_ce_o, ram_we_o, m0_gnt_o, m0_done_o, ram_addr_o} !== {4'b1000, 32'h10}) begin
      bad++; $display("FAIL rd_cycle_n1 got=%b/%h want=1000/10",
                      {ram_ce_o, ram_we_o, m0_gnt_o, m0_done_o}, ram_addr_o);
    end
    @(negedge clk);
    total++;
    if ({m0_done_o, ram_ce_o, m0_rdata_o} !== {2'b10, 32'hA1B2C3D4}) begin
      bad++; $display("FAIL rd_cycle_n2 got=%b/%h want=10/a1b2c3d4", {m0_done_o, ram_ce_o}, m0_rdata_o);
    end
    @(negedge clk);
    total++;
    if ({m0_done_o, m0_rdata_o} !== {1'b0, 32'hA1B2C3D4}) begin
      bad++; $display("FAIL rd_hold got=%b/%h want=0/a1b2c3d4", m0_done_o, m0_rdata_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    logic [31:0] rd;
    do_access(1'b1, 1'b1, 32'h20, 4'hF, 32'hAABBCCDD, rd);
    drive_req(1'b1, 1'b1, 32'h20, 4'b0101, 32'h11223344);
    @(negedge clk);
    total++;
    if ({m1_gnt_o, m0_gnt_o} !== 2'b10) begin bad++; $display("FAIL bw_gnt got=%b want=10", {m1_gnt_o, m0_gnt_o}); end
    @(posedge clk); #1 m1_req_i = 1'b0;
    @(negedge clk);
    total++;
    if ({ram_ce_o, ram_we_o, ram_vldbyte_o, ram_addr_o, ram_wdata_o} !== {6'b110101, 32'h20, 32'h11223344}) begin
      bad++; $display("FAIL bw_access got=%b/%h/%h want=110101/20/11223344",
                      {ram_ce_o, ram_we_o, ram_vldbyte_o}, ram_addr_o, ram_wdata_o);
    end
    @(negedge clk);
    total++;
    if ({m1_done_o, m0_done_o, m1_rdata_o} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL bw_done got=%b/%h want=10/0", {m1_done_o, m0_done_o}, m1_rdata_o);
    end
    @(posedge clk); #1;
    do_access(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, rd);
    total++;
    if (rd !== 32'hAA22CC44) begin bad++; $display("FAIL bw_readback got=%h want=aa22cc44", rd); end
  endtask

  task automatic test_zero_lanes();
    logic [31:0] rd;
    do_access(1'b1, 1'b1, 32'h30, 4'hF, 32'h5A5A5A5A, rd);
    drive_req(1'b0, 1'b1, 32'h30, 4'b0000, 32'hFFFFFFFF);
    @(negedge clk);
    @(posedge clk); #1 m0_req_i = 1'b0;
    @(negedge clk);
    total++;
    if ({ram_ce_o, ram_we_o, ram_vldbyte_o} !== 6'b110000) begin
      bad++; $display("FAIL zl_access got=%b want=110000", {ram_ce_o, ram_we_o, ram_vldbyte_o});
    end
    @(negedge clk);
    total++;
    if ({m0_done_o, m0_rdata_o} !== {1'b1, 32'hAA22CC44}) begin
      bad++; $display("FAIL zl_done got=%b/%h want=1/aa22cc44", m0_done_o, m0_rdata_o);
    end
    @(posedge clk); #1;
    do_access(1'b0, 1'b0, 32'h30, 4'hF, 32'h0, rd);
    total++;
    if (rd !== 32'h5A5A5A5A) begin bad++; $display("FAIL zl_readback got=%h want=5a5a5a5a", rd); end
  endtask

  task automatic test_conflict();
    int g = 0;
    logic [1:0] exp_g;
    do_reset();
    drive_req(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    drive_req(1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    for (int c = 0; c < 40 && g < 8; c++) begin
      @(negedge clk);
      if (m0_gnt_o || m1_gnt_o) begin
        exp_g = (RR && (g % 2 == 1)) ? 2'b10 : 2'b01;
        total++;
        if ({m1_gnt_o, m0_gnt_o} !== exp_g) begin
          bad++; $display("FAIL conflict_gnt%0d got=%b want=%b", g, {m1_gnt_o, m0_gnt_o}, exp_g);
        end
        g++;
      end
    end
    total++;
    if (g != 8) begin bad++; $display("FAIL conflict_count got=%0d want=8", g); end
    drain();
  endtask

  // m1 holds lock for the first lock_beats grants; m0 joins after the first m1 grant.
  task automatic burst_run(input int lock_beats, input int n, output logic [7:0] seq, output int got);
    int beats = 0;
    seq = '0;
    got = 0;
    do_reset();
    drive_req(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    m1_lock_i = (lock_beats > 0);
    for (int c = 0; c < 80 && got < n; c++) begin
      @(negedge clk);
      if (m0_gnt_o || m1_gnt_o) begin
        seq[got] = m1_gnt_o;
        got++;
        if (m1_gnt_o) beats++;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 32'h44, 4'hF, 32'h0);
        m1_lock_i = (beats < lock_beats);
      end
    end
    drain();
  endtask

  task automatic test_burst();
    logic [7:0] seq;
    int got;
    burst_run(100, 5, seq, got);
    total++;
    if (got != 5 || seq[4:0] !== 5'b01111) begin
      bad++; $display("FAIL burst_forced got=%0d/%b want=5/01111", got, seq[4:0]);
    end
    burst_run(1, 3, seq, got);
    total++;
    if (got != 3 || seq[2:0] !== 3'b011) begin
      bad++; $display("FAIL burst_unlock got=%0d/%b want=3/011", got, seq[2:0]);
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    drive_req(1'b1, 1'b0, 32'h48, 4'hF, 32'h0);
    m1_lock_i = 1'b1;
    @(negedge clk);
    total++;
    if ({m1_gnt_o, m0_gnt_o} !== 2'b10) begin bad++; $display("FAIL lh_first got=%b want=10", {m1_gnt_o, m0_gnt_o}); end
    @(posedge clk); #1;
    m1_req_i = 1'b0; m1_lock_i = 1'b0;
    drive_req(1'b0, 1'b0, 32'h4C, 4'hF, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({m1_gnt_o, m0_gnt_o} !== 2'b00) begin bad++; $display("FAIL lh_blocked%0d got=%b want=00", c, {m1_gnt_o, m0_gnt_o}); end
    end
    @(posedge clk); #1 m1_req_i = 1'b1;
    @(negedge clk);
    total++;
    if ({m1_gnt_o, m0_gnt_o} !== 2'b10) begin bad++; $display("FAIL lh_resume got=%b want=10", {m1_gnt_o, m0_gnt_o}); end
    @(posedge clk); #1 m1_req_i = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({m1_gnt_o, m0_gnt_o} !== 2'b01) begin bad++; $display("FAIL lh_release got=%b want=01", {m1_gnt_o, m0_gnt_o}); end
    drain();
  endtask

  task automatic test_reset_access();
    do_reset();
    drive_req(1'b0, 1'b1, 32'h0C, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    @(posedge clk); #1 m0_req_i = 1'b0;
    @(negedge clk);
    total++;
    if ({ram_ce_o, ram_we_o} !== 2'b11) begin bad++; $display("FAIL ra_access got=%b want=11", {ram_ce_o, ram_we_o}); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({ram_ce_o, ram_we_o} !== 2'b00) begin bad++; $display("FAIL ra_drop got=%b want=00", {ram_ce_o, ram_we_o}); end
    @(posedge clk); #1;
    total++;
    if ({m1_done_o, m0_done_o} !== 2'b00) begin bad++; $display("FAIL ra_nodone got=%b want=00", {m1_done_o, m0_done_o}); end
    @(posedge clk); #1 rst_n = 1'b1;
    drive_req(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    drive_req(1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    total++;
    if ({m1_done_o, m0_done_o, m1_gnt_o, m0_gnt_o} !== 4'b0001) begin
      bad++; $display("FAIL ra_first_conflict got=%b want=0001", {m1_done_o, m0_done_o, m1_gnt_o, m0_gnt_o});
    end
    drain();
  endtask

  task automatic test_random();
    txn_t t_acc, t_done, t_new;
    bit pend[2];
    logic we_q[2];
    logic [31:0] ad_q[2], wd_q[2];
    logic [3:0] be_q[2];
    logic [31:0] exp_rd[2];
    logic lk = 1'b0;
    bit m_lock = 1'b0;
    int m_beats = 0;
    int m_last = 1;
    int idx;
    logic [1:0] exp_g, got_g, exp_d;
    do_reset();
    clr_mem = 1'b1;
    @(posedge clk); #1 clr_mem = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    t_acc.vld = 1'b0; t_done.vld = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    got_g = 2'b00;
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (got_g[m]) pend[m] = 1'b0;
        if (!pend[m] && $urandom_range(0, 2) != 0) begin
          pend[m] = 1'b1;
          we_q[m] = 1'($urandom_range(0, 1));
          ad_q[m] = $urandom() & 32'hFFFF_FF3F;
          be_q[m] = 4'($urandom_range(0, 15));
          wd_q[m] = $urandom();
          if (m == 1) lk = ($urandom_range(0, 3) != 0);
        end
      end
      m0_req_i = pend[0]; m0_we_i = we_q[0]; m0_addr_i = ad_q[0]; m0_vldbyte_i = be_q[0]; m0_wdata_i = wd_q[0];
      m1_req_i = pend[1]; m1_we_i = we_q[1]; m1_addr_i = ad_q[1]; m1_vldbyte_i = be_q[1]; m1_wdata_i = wd_q[1];
      m1_lock_i = lk;
      @(negedge clk);
      exp_g = 2'b00;
      if (!t_acc.vld) begin
        if (m_lock) exp_g = {pend[1], 1'b0};
        else if (pend[0] && pend[1]) exp_g = (RR && m_last == 0) ? 2'b10 : 2'b01;
        else exp_g = {pend[1], pend[0]};
      end
      got_g = {m1_gnt_o, m0_gnt_o};
      total++;
      if (got_g !== exp_g) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, got_g, exp_g); end
      total++;
      if (t_acc.vld) begin
        if ({ram_ce_o, ram_we_o, ram_addr_o, ram_vldbyte_o, ram_wdata_o} !==
            {1'b1, t_acc.we, t_acc.addr, t_acc.be, t_acc.wd}) begin
          bad++; $display("FAIL rnd_ram c=%0d got=%b/%h/%h want=1%b/%h/%h", c, {ram_ce_o, ram_we_o},
                          ram_addr_o, ram_wdata_o, t_acc.we, t_acc.addr, t_acc.wd);
        end
      end else if ({ram_ce_o, ram_we_o} !== 2'b00) begin
        bad++; $display("FAIL rnd_ram_idle c=%0d got=%b want=00", c, {ram_ce_o, ram_we_o});
      end
      exp_d = t_done.vld ? ((t_done.m == 1) ? 2'b10 : 2'b01) : 2'b00;
      if (t_done.vld && !t_done.we) exp_rd[t_done.m] = t_done.rd;
      total++;
      if ({m1_done_o, m0_done_o} !== exp_d) begin bad++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, {m1_done_o, m0_done_o}, exp_d); end
      total++;
      if ({m1_rdata_o, m0_rdata_o} !== {exp_rd[1], exp_rd[0]}) begin
        bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h want=%h/%h", c, m1_rdata_o, m0_rdata_o, exp_rd[1], exp_rd[0]);
      end
      t_done = t_acc;
      t_new.vld = 1'b0;
      if (exp_g != 2'b00) begin
        t_new.vld = 1'b1;
        t_new.m = exp_g[1] ? 1 : 0;
        t_new.we = we_q[t_new.m]; t_new.addr = ad_q[t_new.m];
        t_new.be = be_q[t_new.m]; t_new.wd = wd_q[t_new.m];
        idx = int'(t_new.addr[7:2]);
        t_new.rd = ref_mem[idx];
        if (t_new.we)
          for (int b = 0; b < 4; b++)
            if (t_new.be[b]) ref_mem[idx][8*b +: 8] = t_new.wd[8*b +: 8];
        if (t_new.m == 1) begin
          m_beats++;
          if (!lk || m_beats == MB) begin m_lock = 1'b0; m_beats = 0; end
          else m_lock = 1'b1;
        end
        m_last = t_new.m;
      end
      t_acc = t_new;
      @(posedge clk); #1;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_byte_write();
    test_zero_lanes();
    test_conflict();
    test_burst();
    test_lock_hold();
    test_reset_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port data RAM: byte-lane writes on the clock edge, combinational read, active-high chip enable.
- Master 0 is the CPU MEM stage. Master 1 is the debug/program-load port.
- Accepts one request at a time, drives the RAM for exactly one cycle, then returns a completion pulse and read data to the owning master.
- Supports a locked burst mode for master 1, with a bounded length.

Parameters:
ADDR_W, 32, address width of masters and RAM
DATA_W, 32, data width; must be 32 (4 byte lanes)
MAX_BURST, 16, max consecutive locked grants to m1 before forced release (1..255)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
m0_req_i  input  1  m0 request; held with fields stable until m0_gnt_o
m0_we_i  input  1  m0 write (1) / read (0)
m0_addr_i  input  ADDR_W  m0 byte address
m0_vldbyte_i  input  4  m0 byte-lane enables, bit3 = data[31:24]
m0_wdata_i  input  DATA_W  m0 write data
m0_gnt_o  output  1  m0 request accepted this cycle
m0_done_o  output  1  m0 access complete (1-cycle pulse)
m0_rdata_o  output  DATA_W  m0 read data, valid when m0_done_o
m1_req_i, m1_we_i, m1_addr_i, m1_vldbyte_i, m1_wdata_i  input  as m0  m1 request fields
m1_lock_i  input  1  sampled at grant; 1 = more beats follow
m1_gnt_o, m1_done_o  output  1  as m0
m1_rdata_o  output  DATA_W  as m0
ram_ce_o  output  1  RAM chip enable
ram_we_o  output  1  RAM write enable
ram_addr_o  output  ADDR_W  RAM address
ram_vldbyte_o  output  4  RAM byte enables
ram_wdata_o  output  DATA_W  RAM write data
ram_rdata_i  input  DATA_W  RAM combinational read data

Behaviour:
- Reset values: all outputs 0; state IDLE; owner=m0; last_gnt=m1, so m0 wins the first conflict; lock flag 0; burst_cnt 0.
- FSM states are IDLE and ACCESS.
- IDLE:
  - Arbitrate among asserted requests and assert the winner's gnt combinationally in the same cycle.
  - On that edge, latch we/addr/vldbyte/wdata and the owner, then go to ACCESS.
  - With no request, stay in IDLE; all gnt outputs 0.
- ACCESS (exactly 1 cycle):
  - ram_ce_o=1. ram_we_o, ram_addr_o, ram_vldbyte_o and ram_wdata_o come from the latched command.
  - gnt outputs are 0.
  - On the edge: for reads, capture ram_rdata_i into the owner's rdata register. For both reads and writes, set the owner's done for the next cycle. Return to IDLE.
- Latency: request accepted in cycle N → RAM access in cycle N+1 → done/rdata in cycle N+2 (coincides with IDLE).
- Throughput: one access per 2 cycles.
- Outside ACCESS, ram_ce_o=0 and ram_we_o=0; the other RAM outputs hold their last values.
- rdata_o holds until the owner's next read completes. It is not updated by writes.
- Arbitration priority:
  1. Lock flag set: only m1 may be granted; m0 waits.
  2. Only one request: grant it.
  3. Both requesting: apply the policy under Optional Feature.
- Lock:
  - On an m1 grant, set lock = m1_lock_i and burst_cnt = burst_cnt+1.
  - Clear lock and burst_cnt when m1 is granted with m1_lock_i=0.
  - Also clear them when the incremented count reaches MAX_BURST (forced release). The next conflict then goes to m0 regardless of policy.
  - If lock is set but m1 deasserts its request, stay in IDLE with m0 blocked.
- A write with vldbyte=0000 is still sequenced: ce=1, we=1, no lanes written, done pulses.
- Address alignment is not checked; addr is passed through unchanged.
- Asynchronous reset at any point, including during ACCESS: ce/we drop immediately, no done is issued, and the in-flight write is not guaranteed.

Optional Feature:
- Macro RAM_ARB_RR_EN.
- Defined: on a conflict, grant the master not in last_gnt (round-robin). last_gnt updates on every grant.
- Undefined: fixed priority, m0 always wins a conflict. last_gnt is unused. Lock and forced release still apply.

Decomposition:
- Shared defines header/package holds: state encodings (IDLE/ACCESS), master index constants (M0=0, M1=1), RAM bus widths, and the default MAX_BURST.
- One natural sub-module, ram_arb_pick: purely combinational. Inputs are 2 requests, last_gnt and lock; output is a one-hot pick. It contains the RAM_ARB_RR_EN choice.

Test Plan:
1. m0 read, addr 0x10, RAM word 0xA1B2C3D4 → m0_gnt in cycle N; ce=1, we=0, addr 0x10 in N+1; m0_done=1 and m0_rdata=0xA1B2C3D4 in N+2.
2. m1 write, addr 0x20, vldbyte 0101, wdata 0x11223344 → in the ACCESS cycle ram_we=1, vldbyte=0101; a subsequent m0 read of 0x20 returns 0x__22__44 with untouched bytes preserved.
3. m0 and m1 request continuously, RR_EN defined → grant order m0, m1, m0, m1. RR_EN undefined → m0 every grant, m1 never.
4. m1 burst with lock=1, MAX_BURST=4, m0 requesting → four consecutive m1 grants, then m0 granted (forced release). With lock=0 on beat 2 → m0 granted after beat 2.
5. rst_n asserted low in an m0 write ACCESS cycle → ram_ce/ram_we drop to 0 immediately, no m0_done; after release, state IDLE and m0 wins the first conflict.
6. Write with vldbyte=0000 to 0x30 → done pulses; a later read of 0x30 returns the prior contents unchanged.
